mem_access_unit: RTL and testbench

- Sits between the multicycle controller/datapath and a variable-latency unified instruction/data memory.
- Converts the controller's single-cycle MemRead/MemWrite/IRWrite strobes into a req/ack memory handshake.
- Drives a stall signal that freezes the controller's state register while an access is outstanding.
- Owns the instruction register (IR) and the memory data register (MDR) consumed by the datapath.

---
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory access unit: turns controller MemRead/MemWrite strobes into a req/ack
// handshake, stalls the controller while busy, and owns the IR and MDR.
module mem_access_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mreq,
    output logic              mwe,
    output logic [ADDR_W-1:0] maddr,
    output logic [DATA_W-1:0] mwdata,
    input  logic              mack,
    input  logic [DATA_W-1:0] mrdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              stall,
    output logic              done,
    output logic              err,
    input  logic              err_clr
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              mreq_q, mreq_d;
    logic              mwe_q, mwe_d;
    logic              ir_sel_q, ir_sel_d;
    logic              err_q, err_d;
    logic              err_set;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start, illegal;

    assign start   = MemRead ^ MemWrite;
    assign illegal = MemRead & MemWrite;

    always_comb begin
        state_d  = state_q;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        ir_sel_d = ir_sel_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall    = 1'b1;
                    maddr_d  = addr;
                    mwdata_d = wdata;
                    mwe_d    = MemWrite;
                    ir_sel_d = IRWrite & MemRead;
                    mreq_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end else if (illegal) begin
                    err_set = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                // An ack arriving on the last allowed cycle still completes normally.
                if (mack) begin
                    if (!mwe_q) begin
                        mdr_d = mrdata;
                        if (ir_sel_q) ir_d = mrdata;
                    end
                    mreq_d  = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mreq_d  = 1'b0;
                    err_set = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Strobes still show the held controller state here, so they are ignored.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            ir_sel_q <= 1'b0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            ir_sel_q <= ir_sel_d;
            err_q    <= err_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mreq    = mreq_q;
    assign mwe     = mwe_q;
    assign maddr   = maddr_q;
    assign mwdata  = mwdata_q;
    assign ir_out  = ir_q;
    assign mdr_out = mdr_q;
    assign err     = err_q;
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected completions,
// a negedge monitor checks the handshake and pops on each done pulse.
module tb_mem_access_unit;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          MemRead = 1'b0, MemWrite = 1'b0, IRWrite = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          mreq, mwe;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic          mack = 1'b0;
    logic [DW-1:0] mrdata = '0;
    logic [DW-1:0] ir_out, mdr_out;
    logic          stall, done, err;
    logic          err_clr = 1'b0;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .addr(addr), .wdata(wdata), .mreq(mreq), .mwe(mwe),
        .maddr(maddr), .mwdata(mwdata), .mack(mack), .mrdata(mrdata),
        .ir_out(ir_out), .mdr_out(mdr_out), .stall(stall), .done(done),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] ir;
        logic [DW-1:0] mdr;
        logic          err;
        int            nstall;
        int            nreq;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          we;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what IR, MDR and err must hold after each access.
    logic [DW-1:0] ir_m = '0, mdr_m = '0;
    logic          err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle; returns in the same phase.
    task automatic access(input bit wr, input bit irw, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                          input int nb, input bit ack, input bit clr);
        exp_t e;
        if (clr) err_m = 1'b0;
        if (ack && !wr) begin
            mdr_m = rd;
            if (irw) ir_m = rd;
        end
        if (!ack) err_m = 1'b1;
        e.ir = ir_m; e.mdr = mdr_m; e.err = err_m;
        e.nstall = nb + 1; e.nreq = nb;
        e.addr = a; e.wd = wd; e.we = wr;
        exp_q.push_back(e);
        MemRead = !wr; MemWrite = wr; IRWrite = irw;
        addr = a; wdata = wd; err_clr = clr;
        @(posedge clk); #1;
        err_clr = 1'b0;
        for (int k = 1; k <= nb; k++) begin
            addr   = AW'($urandom);
            wdata  = DW'($urandom);
            mack   = ack && (k == nb);
            mrdata = mack ? rd : DW'($urandom);
            @(posedge clk); #1;
        end
        mack = 1'b0;
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
    endtask

    task automatic illegal_req();
        MemRead = 1'b1; MemWrite = 1'b1;
        #1;
        chk("illegal_stall", stall, 0);
        @(posedge clk); #1;
        err_m = 1'b1;
        chk("illegal_mreq", mreq, 0);
        chk("illegal_err", err, err_m);
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        chk("illegal_stays_idle", mreq, 0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        err_m = 1'b0;
        chk("err_clr", err, err_m);
    endtask

    // Monitor
    int st_cnt = 0, rq_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                st_cnt = 0; rq_cnt = 0;
            end else begin
                if (stall) st_cnt++;
                if (mreq) begin
                    rq_cnt++;
                    chk("mreq_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        chk("maddr", maddr, exp_q[0].addr);
                        chk("mwe", mwe, exp_q[0].we);
                        if (exp_q[0].we) chk("mwdata", mwdata, exp_q[0].wd);
                    end
                end
                if (done) begin
                    chk("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("ir_out", ir_out, e.ir);
                        chk("mdr_out", mdr_out, e.mdr);
                        chk("err", err, e.err);
                        chk("stall_cycles", st_cnt, e.nstall);
                        chk("mreq_cycles", rq_cnt, e.nreq);
                        chk("done_no_stall", stall, 0);
                        chk("done_no_mreq", mreq, 0);
                    end
                    st_cnt = 0; rq_cnt = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        bit wr, ack;
        int nb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mreq", mreq, 0);
        chk("rst_mwe", mwe, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_maddr", maddr, 0);
        chk("rst_mwdata", mwdata, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_mdr", mdr_out, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 1'b1, 12'h010, 16'h0000, 16'h8004, 3, 1'b1, 1'b0);
        access(1'b1, 1'b0, 12'h0A5, 16'hBEEF, 16'h0000, 1, 1'b1, 1'b0);
        access(1'b0, 1'b1, 12'h020, 16'h0000, 16'h1234, 1, 1'b1, 1'b0);
        access(1'b0, 1'b0, 12'h030, 16'h0000, 16'h5678, 2, 1'b1, 1'b0);

        access(1'b0, 1'b1, 12'h040, 16'h0000, 16'hCAFE, TO, 1'b0, 1'b0);
        mack = 1'b1; mrdata = 16'hDEAD;
        #1;
        chk("late_mack_stall", stall, 0);
        @(posedge clk); #1;
        mack = 1'b0;
        chk("late_mack_mreq", mreq, 0);
        chk("late_mack_ir", ir_out, ir_m);
        chk("late_mack_mdr", mdr_out, mdr_m);
        chk("late_mack_done", done, 0);
        chk("err_sticky", err, err_m);
        clear_err();

        illegal_req();
        clear_err();
        access(1'b0, 1'b1, 12'h050, 16'h0000, 16'hA5A5, TO, 1'b1, 1'b0);

        // Reset in the middle of a fetch.
        e.ir = ir_m; e.mdr = mdr_m; e.err = err_m; e.nstall = 0; e.nreq = 0;
        e.addr = 12'h060; e.wd = 16'h0000; e.we = 1'b0;
        exp_q.push_back(e);
        MemRead = 1'b1; IRWrite = 1'b1; addr = 12'h060;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        MemRead = 1'b0; IRWrite = 1'b0;
        #1;
        exp_q.delete();
        ir_m = '0; mdr_m = '0; err_m = 1'b0;
        chk("arst_mreq", mreq, 0);
        chk("arst_ir", ir_out, 0);
        chk("arst_mdr", mdr_out, 0);
        chk("arst_stall", stall, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mack = 1'b1; mrdata = 16'h7777;
        @(posedge clk); #1;
        mack = 1'b0;
        chk("arst_mack_ignored_mdr", mdr_out, 0);
        chk("arst_mack_ignored_mreq", mreq, 0);
        access(1'b0, 1'b1, 12'h070, 16'h0000, 16'h4321, 2, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                illegal_req();
            end else begin
                wr  = bit'($urandom_range(0, 1));
                nb  = $urandom_range(1, TO);
                ack = (nb < TO) ? 1'b1 : bit'($urandom_range(0, 1));
                access(wr, bit'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                       DW'($urandom), nb, ack, bit'($urandom_range(0, 2) == 0));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
